// File: rtl/pulse_width_decoder_if.sv
// Pulse-width decoder bus: the pulse being measured plus the width/strobe report.
// The master drives PULSE_IN; the slave (decoder) returns WIDTH, VALID, ERR and BUSY.
interface pulse_width_decoder_if #(
    parameter int unsigned BIT_WIDTH = 4
);
    logic                 PULSE_IN;
    logic [BIT_WIDTH-1:0] WIDTH;
    logic                 VALID;
    logic                 ERR;
    logic                 BUSY;

    modport master (
        output PULSE_IN,
        input  WIDTH,
        input  VALID,
        input  ERR,
        input  BUSY
    );

    modport slave (
        input  PULSE_IN,
        output WIDTH,
        output VALID,
        output ERR,
        output BUSY
    );
endinterface

// File: rtl/pulse_width_decoder.sv
// Measures the high time of PULSE_IN in CLK cycles and strobes VALID/ERR against a window.
// Optional input deglitching is enabled with PULSE_WIDTH_DECODER_GLITCH_FILTER_EN.
module pulse_width_decoder #(
    parameter int unsigned BIT_WIDTH  = 4,
    parameter int unsigned MIN_COUNTS = 10,
    parameter int unsigned MAX_COUNTS = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    pulse_width_decoder_if.slave  bus_io
);

    localparam logic [BIT_WIDTH-1:0] CntMax = '1;
    localparam logic [BIT_WIDTH-1:0] CntOne = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] MinCnt = BIT_WIDTH'(MIN_COUNTS);
    localparam logic [BIT_WIDTH-1:0] MaxCnt = BIT_WIDTH'(MAX_COUNTS);

    typedef enum logic [1:0] {StArm, StIdle, StMeasure} state_e;

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] width_q, width_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 s;
    logic                 arm_ok;

`ifdef PULSE_WIDTH_DECODER_GLITCH_FILTER_EN
    logic q1_q, q2_q, q3_q, s_q, arm_hold_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q1_q       <= 1'b0;
            q2_q       <= 1'b0;
            q3_q       <= 1'b0;
            s_q        <= 1'b0;
            arm_hold_q <= 1'b1;
        end else begin
            q1_q       <= bus_io.PULSE_IN;
            q2_q       <= q1_q;
            q3_q       <= q2_q;
            s_q        <= s;
            arm_hold_q <= 1'b0;
        end
    end

    assign s = (q2_q == q3_q) ? q2_q : s_q;
    // Filter flops clear on reset, so wait until a real low has crossed the whole pipeline.
    assign arm_ok = !arm_hold_q && !q1_q && !q2_q && !q3_q && !s;
`else
    assign s      = bus_io.PULSE_IN;
    assign arm_ok = !s;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StArm;
            cnt_q   <= '0;
            width_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StArm: begin
                if (arm_ok) state_d = StIdle;
            end
            StIdle: begin
                if (s) begin
                    state_d = StMeasure;
                    cnt_d   = CntOne;
                end
            end
            StMeasure: begin
                if (s) begin
                    if (cnt_q != CntMax) cnt_d = cnt_q + CntOne;
                end else begin
                    width_d = cnt_q;
                    state_d = StIdle;
                    // A saturated count is never a trustworthy width.
                    if (cnt_q >= MinCnt && cnt_q <= MaxCnt && cnt_q != CntMax) valid_d = 1'b1;
                    else err_d = 1'b1;
                end
            end
            default: state_d = StArm;
        endcase
    end

    assign bus_io.WIDTH = width_q;
    assign bus_io.VALID = valid_q;
    assign bus_io.ERR   = err_q;
    assign bus_io.BUSY  = (state_q == StMeasure);

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Self-checking bench for pulse_width_decoder: pulses are driven, expected reports are queued
// and a negedge monitor pops and compares each VALID/ERR strobe.
module tb_pulse_width_decoder;

    localparam int BW   = 4;
    localparam int MINC = 10;
    localparam int MAXC = 14;
    localparam int SAT  = (1 << BW) - 1;
`ifdef PULSE_WIDTH_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 3;
    localparam int GAP = 2;
`else
    localparam int LAT = 0;
    localparam int GAP = 1;
`endif

    typedef struct {
        int w;
        bit v;
        int due;
        int blen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   blen = 0;
    bit   busy_prev = 1'b0;
    exp_t sb[$];
    exp_t me;

    pulse_width_decoder_if #(.BIT_WIDTH(BW)) bus ();

    pulse_width_decoder #(
        .BIT_WIDTH (BW),
        .MIN_COUNTS(MINC),
        .MAX_COUNTS(MAXC)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            busy_prev = 1'b0;
        end else begin
            if (bus.BUSY) begin
                if (!busy_prev) blen = 0;
                blen++;
            end
            busy_prev = bus.BUSY;
            if (bus.VALID || bus.ERR) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe: VALID=%b ERR=%b WIDTH=%0d, required no strobe",
                             bus.VALID, bus.ERR, bus.WIDTH);
                end else begin
                    me = sb.pop_front();
                    total++;
                    if (bus.VALID !== me.v || bus.ERR !== !me.v) begin
                        bad++;
                        $display("FAIL strobe_kind: VALID=%b ERR=%b, required VALID=%b ERR=%b",
                                 bus.VALID, bus.ERR, me.v, !me.v);
                    end
                    total++;
                    if (int'(bus.WIDTH) !== me.w) begin
                        bad++;
                        $display("FAIL width: got %0d, required %0d", bus.WIDTH, me.w);
                    end
                    total++;
                    if (cyc !== me.due) begin
                        bad++;
                        $display("FAIL latency: strobe at cycle %0d, required %0d", cyc, me.due);
                    end
                    total++;
                    if (blen !== me.blen) begin
                        bad++;
                        $display("FAIL busy_len: got %0d, required %0d", blen, me.blen);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic drive_pulse(input int n, input int gap);
        exp_t e;
        bus.PULSE_IN = 1'b1;
        repeat (n) @(negedge clk);
        bus.PULSE_IN = 1'b0;
        e.w    = (n > SAT) ? SAT : n;
        e.v    = (e.w >= MINC) && (e.w <= MAXC) && (e.w != SAT);
        e.due  = cyc + 1 + LAT;
        e.blen = n;
        sb.push_back(e);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.PULSE_IN = 1'b0;
        repeat (3) @(negedge clk);
        total += 4;
        if (bus.WIDTH !== '0) begin
            bad++; $display("FAIL reset_width: got %0d, required 0", bus.WIDTH);
        end
        if (bus.VALID !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b, required 0", bus.VALID);
        end
        if (bus.ERR !== 1'b0) begin
            bad++; $display("FAIL reset_err: got %b, required 0", bus.ERR);
        end
        if (bus.BUSY !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b, required 0", bus.BUSY);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_window();
        drive_pulse(12, 4);
        drive_pulse(9, 4);
        drive_pulse(15, 4);
        drive_pulse(10, 4);
        drive_pulse(14, 4);
        wait_drain();
        total += 2;
        if (sb.size() != 0) begin
            bad++; $display("FAIL window_pending: %0d strobes missing, required 0", sb.size());
            sb.delete();
        end
        if (bus.WIDTH !== 4'd14) begin
            bad++; $display("FAIL window_hold: WIDTH=%0d, required 14", bus.WIDTH);
        end
    endtask

    task automatic test_saturation();
        drive_pulse(20, 4);
        wait_drain();
        total += 2;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sat_pending: %0d strobes missing, required 0", sb.size());
            sb.delete();
        end
        if (bus.WIDTH !== 4'd15) begin
            bad++; $display("FAIL sat_hold: WIDTH=%0d, required 15", bus.WIDTH);
        end
    endtask

    task automatic test_high_through_reset();
        rst = 1'b1;
        bus.PULSE_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.BUSY !== 1'b0) begin
                bad++; $display("FAIL armed_busy: BUSY=%b at cycle %0d, required 0", bus.BUSY, i);
            end
        end
        bus.PULSE_IN = 1'b0;
        repeat (6) @(negedge clk);
        drive_pulse(12, 4);
        wait_drain();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL armed_pending: %0d strobes missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_pulse();
        bus.PULSE_IN = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (7) @(negedge clk);
        bus.PULSE_IN = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total += 2;
        if (bus.WIDTH !== '0) begin
            bad++; $display("FAIL midrst_width: got %0d, required 0", bus.WIDTH);
        end
        if (bus.BUSY !== 1'b0) begin
            bad++; $display("FAIL midrst_busy: got %b, required 0", bus.BUSY);
        end
        repeat (4) @(negedge clk);
        drive_pulse(11, 4);
        wait_drain();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL midrst_pending: %0d strobes missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        drive_pulse(12, GAP);
        drive_pulse(12, 4);
        wait_drain();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL b2b_pending: %0d strobes missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_glitch();
`ifdef PULSE_WIDTH_DECODER_GLITCH_FILTER_EN
        bus.PULSE_IN = 1'b1;
        @(negedge clk);
        bus.PULSE_IN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (bus.BUSY !== 1'b0) begin
                bad++; $display("FAIL glitch_busy: BUSY=%b at cycle %0d, required 0", bus.BUSY, i);
            end
        end
`else
        drive_pulse(1, 4);
`endif
        wait_drain();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL glitch_pending: %0d strobes missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        bus.PULSE_IN = 1'b0;
        test_reset();
        test_window();
        test_saturation();
        test_high_through_reset();
        test_reset_mid_pulse();
        test_back_to_back();
        test_glitch();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_width_decoder.md
# pulse_width_decoder

Receiving end of the monostable pulse path: measures the high time of an active-high pulse (as produced by the 555 one-shot model's OUT), in CLK cycles, and classifies it against a valid window. Used downstream of one-shot stages to decode timing pulses into a width value plus a valid/error strobe. All logic is single-clock; the input is sampled on CLK.

## Interface
- BIT_WIDTH, 4: width of the counter and of WIDTH.
- MIN_COUNTS, 10: shortest accepted pulse, in cycles.
- MAX_COUNTS, 14: longest accepted pulse, in cycles. Legal range is 1 ≤ MIN_COUNTS ≤ MAX_COUNTS ≤ 2^BIT_WIDTH−2.

Ports:
- CLK  in  1  clock; all logic on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- PULSE_IN  in  1  pulse under measurement, active-high.
- WIDTH  out  BIT_WIDTH  last measured width, saturating; held between reports.
- VALID  out  1  one-cycle strobe: measured width is within [MIN_COUNTS, MAX_COUNTS].
- ERR  out  1  one-cycle strobe: measured width is outside the window, or saturated.
- BUSY  out  1  high while a pulse is being measured.

## Operation
- s = effective input sample: PULSE_IN directly, or the filtered value (see Configuration).
- FSM states are ARM, IDLE and MEASURE.
  - ARM: wait for s=0, then go to IDLE. A pulse already high when reset is released is never measured.
  - IDLE: on s=1, go to MEASURE with cnt=1.
  - MEASURE, s=1: cnt increments, saturating at 2^BIT_WIDTH−1. It never wraps.
  - MEASURE, s=0: WIDTH←cnt. Assert VALID if MIN_COUNTS ≤ cnt ≤ MAX_COUNTS, otherwise assert ERR. Go to IDLE.
- VALID and ERR are mutually exclusive and never high in consecutive cycles for the same pulse.
- BUSY=1 exactly while state=MEASURE.
- Widths are compared unsigned at BIT_WIDTH bits. A saturated cnt (2^BIT_WIDTH−1) always reports ERR.
- Reset values: state=ARM, cnt=0, WIDTH=0, VALID=0, ERR=0, BUSY=0.
- Reset mid-pulse discards the measurement. No strobe is produced. The FSM restarts in ARM.

## Timing
- Measured width equals the number of consecutive rising edges at which s=1.
- Report latency: VALID/ERR and the new WIDTH are visible in the cycle following the first edge that samples s=0. The strobe lasts exactly 1 cycle.
- Back-to-back pulses: the fall edge moves the FSM to IDLE. A rise sampled at the very next edge starts a new measurement, so the minimum low gap is 1 cycle with no lost pulse.
- A 1-cycle pulse (filter disabled) yields WIDTH=1 and ERR, since it is below the default MIN.
- WIDTH changes only on a report or on reset.

## Configuration
- PULSE_WIDTH_DECODER_GLITCH_FILTER_EN
- Defined:
  - PULSE_IN passes through a 2-flop synchronizer (q1, q2).
  - The filtered s updates to q2 only when q2 has held the same value on 2 consecutive edges.
  - Any input level lasting 1 cycle is ignored.
  - Pulses ≥2 cycles report unchanged widths.
  - Report latency is +3 cycles relative to the undefined build.
  - Filter flops reset to 0.
- Undefined: s = PULSE_IN sampled directly. PULSE_IN must be synchronous to CLK.

## Test plan
- 12-cycle pulse after reset, from a oneshot with COUNTS=12 → WIDTH=12, VALID=1 for 1 cycle, ERR=0, BUSY high 12 cycles.
- Pulses of 9 and 15 cycles → each gives ERR=1 for 1 cycle with WIDTH=9 and WIDTH=15 respectively. Widths 10 and 14 → VALID.
- 20-cycle pulse with BIT_WIDTH=4 → cnt saturates, WIDTH=15, ERR=1, no wrap.
- PULSE_IN high through RST release, falling after 5 cycles, then a 12-cycle pulse → no strobe for the first pulse, VALID with WIDTH=12 for the second.
- RST asserted at cycle 6 of a 12-cycle pulse → no strobe, WIDTH=0. The next clean 11-cycle pulse → VALID, WIDTH=11.
- Two 12-cycle pulses separated by 1 low cycle → two VALID strobes, both WIDTH=12. With PULSE_WIDTH_DECODER_GLITCH_FILTER_EN, a 1-cycle pulse → no BUSY and no strobe.
